apb_slave_regs: RTL and testbench

APB4 completer: the stage directly downstream of the APB master, consuming the PSEL/PENABLE transfers that the master drives from its `valid`/`addr`/`write`/`wdata`/`strb`/`prot` request. It holds a bank of 32-bit registers, inserts a fixed number of wait states, and reports errors on PSLVERR. Word 0 is a read-only ID register. One instance occupies one `sels` slot on the bus.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_slave_regbank.sv | 50 +++++
 rtl/definition.sv | 8 +
 rtl/apb_slave_regs.sv | 152 +++++++++++++++
 tb/tb_apb_slave_regs.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and constants: completer FSM states, default widths, ID word
// and the address-alignment helper.
package apb_pkg;

  localparam int          APB_ADDR_WIDTH = 32;
  localparam int          APB_DATA_WIDTH = 32;
  localparam int          APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam logic [31:0] APB_ID_VALUE   = 32'hA5B0_0001;

  typedef enum logic [1:0] {
    APB_SLV_IDLE,
    APB_SLV_WAIT,
    APB_SLV_DONE
  } apb_slv_state_e;

  function automatic logic apb_addr_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/apb_slave_regbank.sv
// Register storage for apb_slave_regs: words 1..REG_NUM-1 with byte-lane writes,
// word 0 reads back the constant ID.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int          DATA_WIDTH = APB_DATA_WIDTH,
  parameter int          REG_NUM    = 16,
  parameter logic [31:0] ID_VALUE   = APB_ID_VALUE,
  localparam int         STRB_W     = DATA_WIDTH / 8,
  localparam int         IDX_W      = $clog2(REG_NUM)
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [DATA_WIDTH-1:0] ID_WORD = DATA_WIDTH'(ID_VALUE);

  logic [DATA_WIDTH-1:0] mem [1:REG_NUM-1];

  // NOTE: the array is reset word by word because software relies on every
  // register reading 0 after reset; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i < REG_NUM; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < REG_NUM; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (widx == IDX_W'(i) && wstrb[b]) mem[i][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // NOTE: rdata gets a value before any branch so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    rdata = '0;
    if (ridx == '0) rdata = ID_WORD;
    for (int i = 1; i < REG_NUM; i++) begin
      if (ridx == IDX_W'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/definition.sv
// Bus width macros shared by the APB blocks.
`ifndef APB_DEFINITION_SV
`define APB_DEFINITION_SV

`define APB_ADDR_WIDTH 32
`define APB_DATA_WIDTH 32

`endif

// File: rtl/apb_slave_regs.sv
// APB4 completer with a register bank, fixed wait states and PSLVERR reporting.
// Define APB_SLAVE_PROT_CHECK_EN to reject unprivileged writes (pprot[0]=0).
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int          DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int          REG_NUM     = 16,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = APB_ID_VALUE,
  localparam int         STRB_W      = DATA_WIDTH / 8
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_W-1:0]     pstrb,
  input  logic [2:0]            pprot,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  localparam int                    IDX_W      = $clog2(REG_NUM);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * REG_NUM);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
    logic [2:0]            prot;
  } req_t;

  apb_slv_state_e        state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  req_t                  cap;
  logic                  setup, cap_en, done_entry, commit;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_write;
  logic [2:0]            cur_prot;
  logic [IDX_W-1:0]      cur_idx;
  logic                  prot_err, req_err;
  logic                  prot_unused;
  logic [DATA_WIDTH-1:0] rd_word;

  assign setup = psel & ~penable;

  // With zero wait states the response is decided on the setup edge itself,
  // so the live bus is decoded; otherwise the captured request is.
  assign cur_addr  = (state == APB_SLV_IDLE) ? paddr  : cap.addr;
  assign cur_write = (state == APB_SLV_IDLE) ? pwrite : cap.write;
  assign cur_prot  = (state == APB_SLV_IDLE) ? pprot  : cap.prot;
  assign cur_idx   = cur_addr[IDX_W+1:2];

`ifdef APB_SLAVE_PROT_CHECK_EN
  assign prot_err    = cur_write & ~cur_prot[0];
  assign prot_unused = ^cur_prot[2:1];
`else
  assign prot_err    = 1'b0;
  assign prot_unused = ^cur_prot;
`endif

  assign req_err = !apb_addr_aligned(cur_addr[1:0])
                || (cur_addr >= ADDR_LIMIT)
                || (cur_write && cur_idx == '0)
                || prot_err;

  // The write lands only when the master still holds psel at the end of DONE,
  // so an abort or reset during the transfer discards it.
  assign commit = (state == APB_SLV_DONE) & psel & cap.write & ~pslverr;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cap_en     = 1'b0;
    done_entry = 1'b0;
    case (state)
      APB_SLV_IDLE: begin
        if (setup) begin
          cap_en = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = APB_SLV_DONE;
            done_entry = 1'b1;
          end else begin
            state_nxt = APB_SLV_WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      APB_SLV_WAIT: begin
        if (!psel) begin
          state_nxt = APB_SLV_IDLE;
          cnt_nxt   = '0;
        end else if (cnt <= 4'd1) begin
          state_nxt  = APB_SLV_DONE;
          cnt_nxt    = '0;
          done_entry = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      APB_SLV_DONE: state_nxt = APB_SLV_IDLE;
      default:      state_nxt = APB_SLV_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= APB_SLV_IDLE;
      cnt   <= '0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (cap_en) cap <= '{addr: paddr, write: pwrite, wdata: pwdata, strb: pstrb, prot: pprot};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= done_entry;
      pslverr <= done_entry & req_err;
      prdata  <= (done_entry && !req_err && !cur_write) ? rd_word : '0;
    end
  end

  apb_slave_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_NUM    (REG_NUM),
    .ID_VALUE   (ID_VALUE)
  ) u_regbank (
    .clk   (clk),
    .rstn  (rstn),
    .we    (commit),
    .widx  (cap.addr[IDX_W+1:2]),
    .wstrb (cap.strb),
    .wdata (cap.wdata),
    .ridx  (cur_idx),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: three instances with 0, 3 and 2 wait states
// driven by one linear sequence of APB transfers.
module tb_apb_slave_regs;

  localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLAVE_PROT_CHECK_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  psel = '0;
  logic        penable = 1'b0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [31:0] prdata_v [3];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  apb_slave_regs #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .psel(psel[0]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_v[0]), .prdata(prdata_v[0]), .pslverr(pslverr_v[0])
  );

  apb_slave_regs #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .psel(psel[1]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_v[1]), .prdata(prdata_v[1]), .pslverr(pslverr_v[1])
  );

  apb_slave_regs #(.WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .psel(psel[2]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_v[2]), .prdata(prdata_v[2]), .pslverr(pslverr_v[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transfer on instance k; lat is the access-phase cycle (1-based)
  // in which pready was seen, 0 if it never came.
  task automatic xfer(input int k, input logic [31:0] addr, input logic wr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [2:0] prot, output logic [31:0] rd,
                      output logic err, output int lat);
    rd  = 'x;
    err = 1'bx;
    lat = 0;
    @(posedge clk); #1;
    psel    = '0;
    psel[k] = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = data;
    pstrb   = strb;
    pprot   = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pready_v[k]) begin
        lat = i;
        rd  = prdata_v[k];
        err = pslverr_v[k];
        break;
      end
    end
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;
    @(negedge clk);
    check("pready_drop", {31'd0, pready_v[k]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pready0", {31'd0, pready_v[0]}, 32'd0);
    check("rst_pslverr0", {31'd0, pslverr_v[0]}, 32'd0);
    check("rst_prdata0", prdata_v[0], 32'd0);
    check("rst_pready3", {31'd0, pready_v[1]}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Zero wait states: write then read back
    xfer(0, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, rd, err, lat);
    check("w0_lat", lat, 32'd1);
    check("w0_err", {31'd0, err}, 32'd0);
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("r0_lat", lat, 32'd1);
    check("r0_data", rd, 32'hDEADBEEF);
    check("r0_err", {31'd0, err}, 32'd0);

    // Three wait states: ID read, ID write rejected
    xfer(1, 32'h00, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("id_lat", lat, 32'd4);
    check("id_data", rd, ID);
    check("id_err", {31'd0, err}, 32'd0);
    xfer(1, 32'h00, 1'b1, 32'h12345678, 4'hF, 3'b001, rd, err, lat);
    check("idw_lat", lat, 32'd4);
    check("idw_err", {31'd0, err}, 32'd1);
    xfer(1, 32'h00, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("id_keep", rd, ID);

    // Partial strobe merge
    xfer(0, 32'h08, 1'b1, 32'h11223344, 4'hF, 3'b001, rd, err, lat);
    xfer(0, 32'h08, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b001, rd, err, lat);
    check("strb_err", {31'd0, err}, 32'd0);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("strb_data", rd, 32'h11BB33DD);

    // Error cases and boundaries
    xfer(0, 32'h06, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("misal_err", {31'd0, err}, 32'd1);
    check("misal_data", rd, 32'd0);
    xfer(0, 32'h40, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_data", rd, 32'd0);
    xfer(0, 32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, err, lat);
    check("oorw_err", {31'd0, err}, 32'd1);
    xfer(0, 32'h0A, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, err, lat);
    check("misalw_err", {31'd0, err}, 32'd1);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("err_keep08", rd, 32'h11BB33DD);
    xfer(0, 32'h3C, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, rd, err, lat);
    check("last_w_err", {31'd0, err}, 32'd0);
    xfer(0, 32'h3C, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("last_r_data", rd, 32'hCAFEF00D);
    xfer(0, 32'h04, 1'b1, 32'h0BADF00D, 4'h0, 3'b001, rd, err, lat);
    check("strb0_err", {31'd0, err}, 32'd0);
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("strb0_keep", rd, 32'hDEADBEEF);

    // penable high in IDLE without a setup phase is ignored
    @(posedge clk); #1;
    psel[0] = 1'b1;
    penable = 1'b1;
    paddr   = 32'h04;
    pwrite  = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_pen", {31'd0, pready_v[0]}, 32'd0);
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;

    // Protection attribute on writes
    xfer(0, 32'h14, 1'b1, 32'h0BAD0BAD, 4'hF, 3'b000, rd, err, lat);
    check("prot0_err", {31'd0, err}, {31'd0, PROT_EN});
    xfer(0, 32'h14, 1'b0, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("prot0_data", rd, PROT_EN ? 32'd0 : 32'h0BAD0BAD);
    xfer(0, 32'h14, 1'b1, 32'h600D600D, 4'hF, 3'b001, rd, err, lat);
    check("prot1_err", {31'd0, err}, 32'd0);
    xfer(0, 32'h14, 1'b0, 32'h0, 4'h0, 3'b000, rd, err, lat);
    check("prot1_data", rd, 32'h600D600D);

    // Abort mid-WAIT on the two-wait-state instance
    @(posedge clk); #1;
    psel[2] = 1'b1;
    penable = 1'b0;
    paddr   = 32'h0C;
    pwrite  = 1'b1;
    pwdata  = 32'h5;
    pstrb   = 4'hF;
    pprot   = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_wait", {31'd0, pready_v[2]}, 32'd0);
    @(posedge clk); #1;
    psel    = '0;
    penable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_rdy", {31'd0, pready_v[2]}, 32'd0);
    end
    xfer(2, 32'h0C, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("abort_lat", lat, 32'd3);
    check("abort_data", rd, 32'd0);

    // Reset asserted while a read response is on the bus
    @(posedge clk); #1;
    psel[0] = 1'b1;
    penable = 1'b0;
    paddr   = 32'h04;
    pwrite  = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("pre_rst_rdy", {31'd0, pready_v[0]}, 32'd1);
    check("pre_rst_data", prdata_v[0], 32'hDEADBEEF);
    #1 rstn = 1'b0;
    #1;
    check("rst_mid_rdy", {31'd0, pready_v[0]}, 32'd0);
    check("rst_mid_data", prdata_v[0], 32'd0);
    check("rst_mid_err", {31'd0, pslverr_v[0]}, 32'd0);
    psel    = '0;
    penable = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, err, lat);
    check("rst_clr_data", rd, 32'd0);
    check("rst_clr_lat", lat, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
